// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the CPU, the external master and the data-memory port of dmem_arbiter.
interface dmem_arbiter_if;
  logic        cpu_req;
  logic        cpu_wr;
  logic [2:0]  cpu_ctrl;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;

  logic        ext_req;
  logic        ext_wr;
  logic [2:0]  ext_ctrl;
  logic [31:0] ext_addr;
  logic [31:0] ext_wdata;
  logic        ext_ack;
  logic [31:0] ext_rdata;

  logic        dm_wr;
  logic [2:0]  dm_ctrl;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;

  modport slave (
    input  cpu_req, cpu_wr, cpu_ctrl, cpu_addr, cpu_wdata,
    input  ext_req, ext_wr, ext_ctrl, ext_addr, ext_wdata,
    input  dm_rdata,
    output cpu_rdata, cpu_stall, ext_ack, ext_rdata,
    output dm_wr, dm_ctrl, dm_addr, dm_wdata
  );

  modport master (
    output cpu_req, cpu_wr, cpu_ctrl, cpu_addr, cpu_wdata,
    output ext_req, ext_wr, ext_ctrl, ext_addr, ext_wdata,
    output dm_rdata,
    input  cpu_rdata, cpu_stall, ext_ack, ext_rdata,
    input  dm_wr, dm_ctrl, dm_addr, dm_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-cycle CPU/EXT data-memory arbiter. EXT has priority; defining DMEM_ARB_BURST_LIMIT_EN
// grants the CPU after BURST_MAX consecutive EXT grants while it waits.
module dmem_arbiter #(
  parameter int unsigned BURST_MAX = 4
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus,
  output logic [1:0]     owner
);

  if (BURST_MAX < 1) begin : g_bad_burst_max
    $error("BURST_MAX must be at least 1");
  end

  typedef enum logic [1:0] {
    OwnNone = 2'b00,
    OwnCpu  = 2'b01,
    OwnExt  = 2'b10
  } owner_e;

  owner_e owner_q, owner_d;
  logic   cpu_grant, ext_grant;
  logic   burst_hit;

`ifdef DMEM_ARB_BURST_LIMIT_EN
  localparam int unsigned CntW = $clog2(BURST_MAX + 1);
  localparam logic [CntW-1:0] BurstMax = CntW'(BURST_MAX);

  logic [CntW-1:0] burst_cnt_q, burst_cnt_d;

  assign burst_hit = (burst_cnt_q == BurstMax);

  always_comb begin
    burst_cnt_d = burst_cnt_q;
    if (!bus.cpu_req || cpu_grant) begin
      burst_cnt_d = '0;
    end else if (ext_grant && (burst_cnt_q != BurstMax)) begin
      burst_cnt_d = burst_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      burst_cnt_q <= '0;
    end else begin
      burst_cnt_q <= burst_cnt_d;
    end
  end
`else
  assign burst_hit = 1'b0;
`endif

  // Grants are forced off during reset so any in-flight EXT transfer is dropped unacked.
  always_comb begin
    cpu_grant = 1'b0;
    ext_grant = 1'b0;
    if (!rst) begin
      if (bus.ext_req && !(bus.cpu_req && burst_hit)) begin
        ext_grant = 1'b1;
      end else if (bus.cpu_req) begin
        cpu_grant = 1'b1;
      end
    end
  end

  always_comb begin
    bus.dm_wr     = 1'b0;
    bus.dm_ctrl   = 3'b000;
    bus.dm_addr   = 32'h0;
    bus.dm_wdata  = 32'h0;
    bus.cpu_rdata = 32'h0;
    bus.ext_rdata = 32'h0;
    owner_d       = OwnNone;
    if (cpu_grant) begin
      bus.dm_wr     = bus.cpu_wr;
      bus.dm_ctrl   = bus.cpu_ctrl;
      bus.dm_addr   = bus.cpu_addr;
      bus.dm_wdata  = bus.cpu_wdata;
      bus.cpu_rdata = bus.dm_rdata;
      owner_d       = OwnCpu;
    end else if (ext_grant) begin
      bus.dm_wr     = bus.ext_wr;
      bus.dm_ctrl   = bus.ext_ctrl;
      bus.dm_addr   = bus.ext_addr;
      bus.dm_wdata  = bus.ext_wdata;
      bus.ext_rdata = bus.dm_rdata;
      owner_d       = OwnExt;
    end
  end

  assign bus.cpu_stall = bus.cpu_req & ~cpu_grant & ~rst;
  assign bus.ext_ack   = ext_grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= OwnNone;
    end else begin
      owner_q <= owner_d;
    end
  end

  assign owner = owner_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: single-cycle vector table plus contention/reset sequences.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_BURST_LIMIT_EN
  localparam bit LimitEn = 1'b1;
`else
  localparam bit LimitEn = 1'b0;
`endif
  localparam int unsigned BurstMax = 4;

  logic       clk;
  logic       rst;
  logic [1:0] owner;
  int         n_chk;
  int         n_fail;

  dmem_arbiter_if bus ();

  dmem_arbiter #(
    .BURST_MAX (BurstMax)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .owner (owner)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rst;
    logic        cpu_req;
    logic        cpu_wr;
    logic [2:0]  cpu_ctrl;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        ext_req;
    logic        ext_wr;
    logic [2:0]  ext_ctrl;
    logic [31:0] ext_addr;
    logic [31:0] ext_wdata;
    logic [31:0] mem;
    logic        e_dm_wr;
    logic [2:0]  e_dm_ctrl;
    logic [31:0] e_dm_addr;
    logic [31:0] e_dm_wdata;
    logic [31:0] e_cpu_rdata;
    logic        e_stall;
    logic        e_ack;
    logic [31:0] e_ext_rdata;
    logic [1:0]  e_owner;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic creq, input logic cwr, input logic [2:0] cctl,
                       input logic [31:0] caddr, input logic [31:0] cwd, input logic ereq,
                       input logic ewr, input logic [2:0] ectl, input logic [31:0] eaddr,
                       input logic [31:0] ewd, input logic [31:0] mem);
    rst           = r;
    bus.cpu_req   = creq;
    bus.cpu_wr    = cwr;
    bus.cpu_ctrl  = cctl;
    bus.cpu_addr  = caddr;
    bus.cpu_wdata = cwd;
    bus.ext_req   = ereq;
    bus.ext_wr    = ewr;
    bus.ext_ctrl  = ectl;
    bus.ext_addr  = eaddr;
    bus.ext_wdata = ewd;
    bus.dm_rdata  = mem;
  endtask

  // One contended (or EXT-only when creq=0) cycle; called just after a posedge.
  task automatic cont_cycle(input string tag, input logic r, input logic creq, input bit exp_ext);
    bit exp_cpu;
    exp_cpu = !r && creq && !exp_ext;
    drive(r, creq, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 1'b1, 1'b1, 3'b010, 32'h0000_0200,
          32'h0000_ABCD, 32'h0000_5A5A);
    #3;
    chk({tag, " ext_ack"}, 32'(bus.ext_ack), 32'(exp_ext));
    chk({tag, " cpu_stall"}, 32'(bus.cpu_stall), 32'(!r && creq && exp_ext));
    chk({tag, " dm_addr"}, bus.dm_addr,
        exp_ext ? 32'h0000_0200 : (exp_cpu ? 32'h0000_0100 : 32'h0));
    chk({tag, " dm_wr"}, 32'(bus.dm_wr), 32'(exp_ext));
    @(posedge clk);
    #1;
    chk({tag, " owner"}, 32'(owner), exp_ext ? 32'd2 : (exp_cpu ? 32'd1 : 32'd0));
  endtask

  task automatic idle_cycle();
    drive(1'b0, 1'b0, 1'b0, 3'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3'b0, 32'h0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    drive(1'b1, 1'b0, 1'b0, 3'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3'b0, 32'h0, 32'h0, 32'h0);

    //        rst creq cwr cctl    caddr         cwdata        ereq ewr ectl   eaddr
    //        ewdata        mem           dm_wr ctl   addr          wdata         cpu_rd
    //        stall ack ext_rd      owner
    vecs[0] = '{1'b1, 1'b1, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b1, 1'b1, 3'b010, 32'h20,
                32'h55, 32'hAAAA, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 2'b00};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 3'b000, 32'h0,
                32'h0, 32'hAAAA, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'hAAAA, 1'b0, 1'b0,
                32'h0, 2'b01};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b1, 1'b0, 3'b010, 32'h20,
                32'h55, 32'h12345678, 1'b0, 3'b010, 32'h20, 32'h55, 32'h0, 1'b0, 1'b1,
                32'h12345678, 2'b10};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 3'b111, 32'h4, 32'h9, 1'b0, 1'b1, 3'b101, 32'h8,
                32'h7, 32'h777, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 2'b00};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 3'b100, 32'h44, 32'h1, 1'b0, 1'b0, 3'b000, 32'h0,
                32'h0, 32'hCAFE0001, 1'b0, 3'b100, 32'h44, 32'h1, 32'hCAFE0001, 1'b0, 1'b0,
                32'h0, 2'b01};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 3'b010, 32'h8, 32'h3, 1'b1, 1'b1, 3'b001, 32'h30,
                32'hBEEF, 32'h99, 1'b1, 3'b001, 32'h30, 32'hBEEF, 32'h0, 1'b1, 1'b1,
                32'h99, 2'b10};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b1, 1'b1, 3'b000, 32'h34,
                32'h1234, 32'h0, 1'b1, 3'b000, 32'h34, 32'h1234, 32'h0, 1'b0, 1'b1,
                32'h0, 2'b10};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 3'b011, 32'hC, 32'hF, 1'b0, 1'b1, 3'b110, 32'hE,
                32'h11, 32'h42, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 2'b00};
    vecs[8] = '{1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b1, 1'b1, 3'b010, 32'h50,
                32'h66, 32'hFF, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 2'b00};

    @(posedge clk);
    #1;
    chk("reset owner", 32'(owner), 32'd0);

    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].rst, vecs[i].cpu_req, vecs[i].cpu_wr, vecs[i].cpu_ctrl, vecs[i].cpu_addr,
            vecs[i].cpu_wdata, vecs[i].ext_req, vecs[i].ext_wr, vecs[i].ext_ctrl,
            vecs[i].ext_addr, vecs[i].ext_wdata, vecs[i].mem);
      #3;
      chk($sformatf("v%0d dm_wr", i), 32'(bus.dm_wr), 32'(vecs[i].e_dm_wr));
      chk($sformatf("v%0d dm_ctrl", i), 32'(bus.dm_ctrl), 32'(vecs[i].e_dm_ctrl));
      chk($sformatf("v%0d dm_addr", i), bus.dm_addr, vecs[i].e_dm_addr);
      chk($sformatf("v%0d dm_wdata", i), bus.dm_wdata, vecs[i].e_dm_wdata);
      chk($sformatf("v%0d cpu_rdata", i), bus.cpu_rdata, vecs[i].e_cpu_rdata);
      chk($sformatf("v%0d cpu_stall", i), 32'(bus.cpu_stall), 32'(vecs[i].e_stall));
      chk($sformatf("v%0d ext_ack", i), 32'(bus.ext_ack), 32'(vecs[i].e_ack));
      chk($sformatf("v%0d ext_rdata", i), bus.ext_rdata, vecs[i].e_ext_rdata);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d owner", i), 32'(owner), 32'(vecs[i].e_owner));
    end

    // Ten contended cycles: CPU wins cycles 4 and 9 only when the burst limit is built in.
    idle_cycle();
    for (int i = 0; i < 10; i++) begin
      cont_cycle($sformatf("burst c%0d", i), 1'b0, 1'b1, !(LimitEn && (i == 4 || i == 9)));
    end

    // A cpu_req=0 cycle clears the burst count mid-run.
    idle_cycle();
    for (int i = 0; i < 3; i++) cont_cycle($sformatf("gap pre%0d", i), 1'b0, 1'b1, 1'b1);
    cont_cycle("gap hole", 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cont_cycle($sformatf("gap post%0d", i), 1'b0, 1'b1, !(LimitEn && i == 4));
    end

    // Reset mid-burst drops the pending EXT transfer and restarts the count.
    idle_cycle();
    for (int i = 0; i < 2; i++) cont_cycle($sformatf("rst pre%0d", i), 1'b0, 1'b1, 1'b1);
    cont_cycle("rst pulse", 1'b1, 1'b1, 1'b0);
    chk("rst ext_rdata", bus.ext_rdata, 32'h0);
    for (int i = 0; i < 5; i++) begin
      cont_cycle($sformatf("rst post%0d", i), 1'b0, 1'b1, !(LimitEn && i == 4));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have a single clock and a synchronous, active-high reset, and SHALL be parameterised as listed in REQ-002.
REQ-002 Parameter: BURST_MAX, default 4, maximum consecutive EXT grants while the CPU waits (legal range >=1).
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 cpu_req  in  1  CPU load/store pending this cycle.
REQ-006 cpu_wr  in  1  CPU store (1) / load (0).
REQ-007 cpu_ctrl  in  3  CPU access size/sign (DMCtrl encoding).
REQ-008 cpu_addr, cpu_wdata  in  32 each  CPU address, store data.
REQ-009 cpu_rdata  out  32  load data to CPU write-back mux.
REQ-010 cpu_stall  out  1  CPU access not granted; PC and register write SHALL be held.
REQ-011 ext_req, ext_wr  in  1 each  external master (loader/debug) request, write.
REQ-012 ext_ctrl  in  3; ext_addr, ext_wdata  in  32  external access fields.
REQ-013 ext_ack  out  1  external transfer completes this cycle.
REQ-014 ext_rdata  out  32  read data to external master.
REQ-015 dm_wr  out  1; dm_ctrl  out  3; dm_addr, dm_wdata  out  32  data-memory port.
REQ-016 dm_rdata  in  32  combinational data-memory read data.
REQ-017 owner  out  2  registered last grant: 00 none, 01 CPU, 10 EXT.

Function
REQ-018 Grant SHALL be decided combinationally each cycle from the requests, burst_cnt and the configuration; each transfer takes one cycle (zero added latency).
REQ-019 Only cpu_req asserted SHALL grant CPU; only ext_req asserted SHALL grant EXT; neither SHALL grant none.
REQ-020 Both asserted SHALL grant EXT, except CPU SHALL be granted when burst_cnt==BURST_MAX (DMEM_ARB_BURST_LIMIT_EN defined).
REQ-021 The dm_* outputs SHALL carry the granted requester's fields; with no grant, dm_wr=0 and dm_ctrl, dm_addr, dm_wdata=0.
REQ-022 cpu_rdata SHALL equal dm_rdata when CPU is granted, else 0; ext_rdata SHALL equal dm_rdata when EXT is granted, else 0.
REQ-023 cpu_stall SHALL equal cpu_req AND NOT cpu_grant; ext_ack SHALL equal ext_grant.
REQ-024 The CPU SHALL hold its cpu_* fields stable while stalled; EXT SHALL hold its fields until ext_ack, and ext_req held high after an ack SHALL start the next transfer.
REQ-025 The owner FSM (NONE/CPU/EXT) SHALL register the current grant at every edge.
REQ-026 burst_cnt, width clog2(BURST_MAX+1), SHALL:
- increment on an EXT grant while cpu_req=1, saturating at BURST_MAX;
- clear on a CPU grant, or in any cycle with cpu_req=0.

Reset
REQ-027 While rst=1: ext_ack=0, dm_wr=0, cpu_stall=0, and all dm_*/rdata outputs =0.
REQ-028 Reset SHALL set owner=00 and burst_cnt=0 at the clock edge.
REQ-029 An EXT transfer not yet acked when reset asserts SHALL be dropped; EXT reissues after reset.

Configuration
REQ-030 Macro DMEM_ARB_BURST_LIMIT_EN, when defined, SHALL compile in burst_cnt and the CPU-fairness rule of REQ-020.
REQ-031 When DMEM_ARB_BURST_LIMIT_EN is undefined, EXT SHALL have strict priority, burst_cnt SHALL not exist, and CPU starvation is permitted.

Verification
REQ-032 CPU-only store, addr 0x10, wdata 0xDEADBEEF -> dm_wr=1 and dm_addr=0x10 in the same cycle; cpu_stall=0; owner=01 next cycle.
REQ-033 EXT-only read of addr 0x20, memory holds 0x12345678 -> ext_ack=1 and ext_rdata=0x12345678 in the same cycle; cpu_rdata=0.
REQ-034 Macro on, BURST_MAX=4, both requesting for 10 cycles -> EXT on cycles 0-3 and 5-8, CPU on cycles 4 and 9; cpu_stall=1 on EXT cycles.
REQ-035 Macro off, same stimulus as REQ-034 -> EXT granted all 10 cycles; cpu_stall=1 throughout.
REQ-036 Macro on, 3 EXT grants with cpu_req=1, then cpu_req=0 for one cycle, then cpu_req=1 again -> 4 further EXT grants before the CPU is granted.
REQ-037 rst pulsed after 2 contended EXT grants -> during rst ext_ack=0 and dm_wr=0; afterwards owner=00 and burst_cnt restarts from 0 (4 EXT grants before CPU).
